// File: rtl/ysyx_24110026_ifu_pkg.sv
// Shared types for the instruction fetch unit.
// Holds the fetch FSM encoding and the {pc, inst} buffer entry.
package ysyx_24110026_ifu_pkg;

   localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

   typedef enum logic [1:0] {
      IFU_REQ  = 2'd0,
      IFU_WAIT = 2'd1,
      IFU_HOLD = 2'd2
   } ifu_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ifu_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ysyx_24110026_ifu_buf.sv
// Single-entry {pc, inst} register with valid/ready output and flush.
// Flush wins over load so a redirect never lets a stale word through.
module ysyx_24110026_ifu_buf
   import ysyx_24110026_ifu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       load,
   input  ifu_entry_t load_entry,
   input  logic       out_ready,
   output logic       out_valid,
   output ifu_entry_t out_entry
);

   logic       valid_q, valid_d;
   ifu_entry_t entry_q, entry_d;

   always_comb begin
      valid_d = valid_q;
      entry_d = entry_q;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      if (load) begin
         valid_d = 1'b1;
         entry_d = load_entry;
      end
      if (flush) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         entry_q <= '0;
      end else begin
         valid_q <= valid_d;
         entry_q <= entry_d;
      end
   end

   assign out_valid = valid_q;
   assign out_entry = entry_q;

endmodule

// File: rtl/ysyx_24110026_ifu.sv
// Instruction fetch unit: one outstanding imem request, single-entry
// output buffer, redirect with kill of the in-flight response.
module ysyx_24110026_ifu
   import ysyx_24110026_ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IFU_RESET_PC,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] inst,
   output logic [31:0]     fetch_cnt
);

   ifu_state_e      state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            kill_q, kill_d;
   logic [31:0]     fetch_cnt_q, fetch_cnt_d;
   logic            req_fire;
   logic            rsp_take;
   logic            deliver;
   logic            buf_load;
   logic            buf_valid;
   ifu_entry_t      buf_entry;
   ifu_entry_t      load_entry;

   assign req_fire = imem_req_valid && imem_req_ready;
   assign rsp_take = (state_q == IFU_WAIT) && imem_rsp_valid;
   assign deliver  = buf_valid && inst_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IFU_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, fetch pc and kill flag
   always_comb begin
      state_d    = state_q;
      kill_d     = kill_q;
      fetch_pc_d = fetch_pc_q;
      buf_load   = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = word_align(redirect_pc);
         case (state_q)
            IFU_REQ: begin
               if (req_fire) begin
                  state_d = IFU_WAIT;
                  kill_d  = 1'b1;
               end
            end
            IFU_WAIT: begin
               if (rsp_take) begin
                  state_d = IFU_REQ;
                  kill_d  = 1'b0;
               end else begin
                  kill_d  = 1'b1;
               end
            end
            default: state_d = IFU_REQ;
         endcase
      end else begin
         case (state_q)
            IFU_REQ: begin
               if (req_fire) begin
                  state_d = IFU_WAIT;
               end
            end
            IFU_WAIT: begin
               if (rsp_take) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = IFU_REQ;
                  end else begin
                     buf_load   = 1'b1;
                     fetch_pc_d = fetch_pc_q + 32'd4;
                     // keep fetching only while the decoder is draining
                     state_d    = inst_ready ? IFU_REQ : IFU_HOLD;
                  end
               end
            end
            IFU_HOLD: begin
               if (deliver) begin
                  state_d = IFU_REQ;
               end
            end
            default: state_d = IFU_REQ;
         endcase
      end
   end

   // A request may only fire if its response cannot land on a full buffer
   always_comb begin
      imem_req_valid = 1'b0;
      if ((state_q == IFU_REQ) && !rst) begin
         imem_req_valid = !buf_valid || inst_ready;
      end
   end

   assign imem_req_addr = fetch_pc_q;
   assign fetch_cnt_d   = fetch_cnt_q + {31'd0, deliver};

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q  <= RESET_PC;
         kill_q      <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         kill_q      <= kill_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign load_entry = '{pc: fetch_pc_q, inst: imem_rsp_data};

   ysyx_24110026_ifu_buf u_buf (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .load       (buf_load),
      .load_entry (load_entry),
      .out_ready  (inst_ready),
      .out_valid  (buf_valid),
      .out_entry  (buf_entry)
   );

   assign inst_valid = buf_valid;
   assign pc         = buf_entry.pc;
   assign inst       = buf_entry.inst;
   assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_24110026_ifu.sv
// Bench for ysyx_24110026_ifu: memory model, directed scenarios,
// then random traffic checked against a sequential-pc scoreboard.
module tb_ysyx_24110026_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] pc;
   logic [31:0] inst;
   logic [31:0] fetch_cnt;

   int checks = 0;
   int errors = 0;
   int lat_cfg = 1;
   int rdy_mode = 1;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        sbq[$];
   exp_t        e;
   logic [31:0] exp_pc;
   int unsigned deliv_cnt;

   always #5 clk = ~clk;

   ysyx_24110026_ifu dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .pc             (pc),
      .inst           (inst),
      .fetch_cnt      (fetch_cnt)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void push_exp();
      sbq.push_back('{exp_pc, mem_word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
   endfunction

   // Memory model: one response per accepted request after lat cycles
   logic        pend;
   logic [31:0] paddr;
   int          pcnt;
   logic        s_fire;
   logic [31:0] s_addr;

   initial begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      pend  = 1'b0;
      paddr = '0;
      pcnt  = 0;
      forever begin
         @(negedge clk);
         s_fire = imem_req_valid && imem_req_ready;
         s_addr = imem_req_addr;
         @(posedge clk);
         #1;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         if (s_fire) begin
            chk("one_outstanding", 32'(pend), 32'd0);
            pend  = 1'b1;
            paddr = s_addr;
            pcnt  = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
         end
         if (pend) begin
            if (pcnt <= 1) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(paddr);
               pend = 1'b0;
            end else begin
               pcnt--;
            end
         end
         case (rdy_mode)
            0:       imem_req_ready = 1'($urandom_range(0, 1));
            1:       imem_req_ready = 1'b1;
            default: imem_req_ready = 1'b0;
         endcase
      end
   end

   // Monitor: deliveries must follow the pc stream restarted at each redirect
   logic        prev_hold;
   logic [31:0] prev_pc;
   logic [31:0] prev_inst;

   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         exp_pc    = RST_PC;
         deliv_cnt = 0;
         prev_hold = 1'b0;
      end else begin
         chk("fetch_cnt", fetch_cnt, deliv_cnt);
         if (prev_hold) begin
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_pc", pc, prev_pc);
            chk("hold_inst", inst, prev_inst);
         end
         if (inst_valid && inst_ready) begin
            if (sbq.size() == 0) push_exp();
            e = sbq.pop_front();
            chk("deliver_pc", pc, e.pc);
            chk("deliver_inst", inst, e.inst);
            deliv_cnt++;
         end
         prev_hold = inst_valid && !inst_ready && !redirect_valid;
         prev_pc   = pc;
         prev_inst = inst;
         if (redirect_valid) begin
            sbq.delete();
            exp_pc = redirect_pc & ~32'h3;
         end
         while (sbq.size() < 2) push_exp();
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic adv();
      cyc();
      smp();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      repeat (5) cyc();
      rst = 1'b0;
   endtask

   initial begin
      bit          found;
      logic [31:0] faddr;
      int unsigned d0;

      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b0;

      // reset state
      repeat (2) cyc();
      smp();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_fetch_cnt", fetch_cnt, 32'd0);

      // 1: streaming with 1-cycle memory
      lat_cfg = 1; rdy_mode = 1; inst_ready = 1'b1;
      do_reset();
      smp();
      chk("t1_req_valid0", 32'(imem_req_valid), 32'd1);
      chk("t1_addr0", imem_req_addr, 32'h8000_0000);
      adv();
      chk("t1_wait_req", 32'(imem_req_valid), 32'd0);
      adv();
      chk("t1_valid_a", 32'(inst_valid), 32'd1);
      chk("t1_addr1", imem_req_addr, 32'h8000_0004);
      adv();
      chk("t1_bubble", 32'(inst_valid), 32'd0);
      adv();
      chk("t1_valid_b", 32'(inst_valid), 32'd1);
      chk("t1_addr2", imem_req_addr, 32'h8000_0008);
      adv();
      adv();
      chk("t1_valid_c", 32'(inst_valid), 32'd1);
      adv();
      chk("t1_cnt3", fetch_cnt, 32'd3);

      // 2: decoder stall holds the entry and blocks fetch
      lat_cfg = 1; rdy_mode = 1; inst_ready = 1'b0;
      do_reset();
      smp();
      adv();
      for (int i = 0; i < 5; i++) begin
         adv();
         chk("t2_valid", 32'(inst_valid), 32'd1);
         chk("t2_pc", pc, RST_PC);
         chk("t2_inst", inst, mem_word(RST_PC));
         chk("t2_no_req", 32'(imem_req_valid), 32'd0);
      end
      cyc();
      inst_ready = 1'b1;
      smp();
      chk("t2_req_same", 32'(imem_req_valid), 32'd0);
      adv();
      chk("t2_req_next", 32'(imem_req_valid), 32'd1);
      chk("t2_addr_next", imem_req_addr, 32'h8000_0004);

      // 3: memory not ready, redirect during the stall
      lat_cfg = 1; rdy_mode = 2; inst_ready = 1'b1;
      do_reset();
      smp();
      chk("t3_valid0", 32'(imem_req_valid), 32'd1);
      chk("t3_addr0", imem_req_addr, 32'h8000_0000);
      adv();
      chk("t3_valid1", 32'(imem_req_valid), 32'd1);
      chk("t3_addr1", imem_req_addr, 32'h8000_0000);
      cyc();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0102;
      smp();
      chk("t3_addr2", imem_req_addr, 32'h8000_0000);
      cyc();
      redirect_valid = 1'b0;
      rdy_mode = 1;
      smp();
      chk("t3_valid_rd", 32'(imem_req_valid), 32'd1);
      chk("t3_addr_rd", imem_req_addr, 32'h8000_0100);
      d0 = deliv_cnt;
      repeat (10) adv();
      chk("t3_progress", 32'(deliv_cnt > d0), 32'd1);

      // 4: redirect while waiting, late response is killed
      lat_cfg = 5; rdy_mode = 1; inst_ready = 1'b1;
      do_reset();
      smp();
      chk("t4_fire", 32'(imem_req_valid), 32'd1);
      cyc();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_1000;
      smp();
      cyc();
      redirect_valid = 1'b0;
      smp();
      for (int i = 0; i < 4; i++) begin
         chk("t4_no_valid", 32'(inst_valid), 32'd0);
         chk("t4_no_req", 32'(imem_req_valid), 32'd0);
         adv();
      end
      lat_cfg = 1;
      chk("t4_req", 32'(imem_req_valid), 32'd1);
      chk("t4_addr", imem_req_addr, 32'h8000_1000);
      chk("t4_dropped", 32'(inst_valid), 32'd0);
      chk("t4_cnt", fetch_cnt, 32'd0);
      repeat (8) adv();

      // 5: redirect in the same cycle as a delivery
      lat_cfg = 1; rdy_mode = 1; inst_ready = 1'b1;
      do_reset();
      smp();
      adv();
      cyc();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_2000;
      smp();
      chk("t5_valid", 32'(inst_valid), 32'd1);
      cyc();
      redirect_valid = 1'b0;
      smp();
      chk("t5_flushed", 32'(inst_valid), 32'd0);
      chk("t5_cnt", fetch_cnt, 32'd1);
      found = 1'b0;
      faddr = '0;
      for (int i = 0; i < 8; i++) begin
         if (!found && imem_req_valid && imem_req_ready) begin
            found = 1'b1;
            faddr = imem_req_addr;
         end
         adv();
      end
      chk("t5_req_seen", 32'(found), 32'd1);
      chk("t5_target", faddr, 32'h8000_2000);

      // 6: reset while a response is due
      lat_cfg = 2; rdy_mode = 1; inst_ready = 1'b1;
      do_reset();
      smp();
      chk("t6_fire", 32'(imem_req_valid), 32'd1);
      cyc();
      rst = 1'b1;
      smp();
      cyc();
      rst = 1'b0;
      smp();
      chk("t6_req", 32'(imem_req_valid), 32'd1);
      chk("t6_addr", imem_req_addr, RST_PC);
      chk("t6_cnt", fetch_cnt, 32'd0);
      chk("t6_no_valid0", 32'(inst_valid), 32'd0);
      adv();
      chk("t6_no_valid1", 32'(inst_valid), 32'd0);
      adv();
      adv();
      chk("t6_valid", 32'(inst_valid), 32'd1);
      chk("t6_pc", pc, RST_PC);

      // random traffic, including redirects near the top of memory
      lat_cfg = 0; rdy_mode = 0; inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cyc();
         inst_ready     = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0) begin
            redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         end else begin
            redirect_pc = 32'h8000_0000 + 32'($urandom_range(0, 255));
         end
      end
      cyc();
      redirect_valid = 1'b0;
      smp();
      chk("rand_progress", 32'(deliv_cnt > 100), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
